// File: rtl/csa_byte_sequencer_pkg.sv
// Shared types for the multi-byte carry-skip add/subtract sequencer.
package csa_seq_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/csa_byte_sequencer_if.sv
// Operand-in / result-out byte streams of csa_byte_sequencer.
interface csa_byte_sequencer_if;
    import csa_seq_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [BYTE_W-1:0] a_byte;
    logic [BYTE_W-1:0] b_byte;
    logic [BYTE_W-1:0] res_byte;
    logic              res_valid;
    logic              res_ready;
    logic              res_last;

    modport master (
        output in_valid, a_byte, b_byte, res_ready,
        input  in_ready, res_byte, res_valid, res_last
    );

    modport slave (
        input  in_valid, a_byte, b_byte, res_ready,
        output in_ready, res_byte, res_valid, res_last
    );

endinterface

// File: rtl/csa_byte_sequencer.sv
// Time-shares one external 8-bit carry-skip adder to add/subtract NBYTES-wide operands LSB first.
// Define CSA_SEQ_ZFLAG_EN to add the 'zero' result flag.
module csa_byte_sequencer
    import csa_seq_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 sub,
    csa_byte_sequencer_if.slave  io,
    output logic [BYTE_W-1:0]    add_a,
    output logic [BYTE_W-1:0]    add_b,
    output logic                 add_cin,
    input  logic [BYTE_W-1:0]    add_sum,
    input  logic                 add_cout,
    output logic                 busy,
    output logic                 done,
    output logic                 carry_out,
    output logic                 overflow
`ifdef CSA_SEQ_ZFLAG_EN
    ,
    output logic                 zero
`endif
);

    localparam int CNT_W = $clog2(NBYTES) + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBYTES - 1);

    state_e            state_q, state_d;
    logic              sub_q, sub_d;
    logic              carry_q, carry_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [BYTE_W-1:0] res_byte_q, res_byte_d;
    logic              res_valid_q, res_valid_d;
    logic              res_last_q, res_last_d;
    logic              done_q, done_d;
    logic              carry_out_q, carry_out_d;
    logic              overflow_q, overflow_d;
    logic              in_ready_w;
    logic              accept;
    logic              consume;
`ifdef CSA_SEQ_ZFLAG_EN
    logic              zacc_q, zacc_d;
    logic              zero_q, zero_d;
`endif

    // NOTE: every variable gets a default before any branch, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        sub_d       = sub_q;
        carry_d     = carry_q;
        count_d     = count_q;
        res_byte_d  = res_byte_q;
        res_valid_d = res_valid_q;
        res_last_d  = res_last_q;
        done_d      = 1'b0;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;
`ifdef CSA_SEQ_ZFLAG_EN
        zacc_d      = zacc_q;
        zero_d      = zero_q;
`endif
        add_a       = '0;
        add_b       = '0;
        add_cin     = 1'b0;

        // Subtract is A + ~B + 1: the initial carry supplies the +1.
        if (state_q == RUN) begin
            add_a   = io.a_byte;
            add_b   = sub_q ? ~io.b_byte : io.b_byte;
            add_cin = carry_q;
        end

        in_ready_w = (state_q == RUN) && (!res_valid_q || io.res_ready);
        accept     = in_ready_w && io.in_valid;
        consume    = res_valid_q && io.res_ready;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = RUN;
                    sub_d       = sub;
                    carry_d     = sub;
                    count_d     = '0;
                    carry_out_d = 1'b0;
                    overflow_d  = 1'b0;
`ifdef CSA_SEQ_ZFLAG_EN
                    zacc_d      = 1'b1;
                    zero_d      = 1'b0;
`endif
                end
            end
            RUN: begin
                if (consume) res_valid_d = 1'b0;
                if (accept) begin
                    res_byte_d  = add_sum;
                    res_valid_d = 1'b1;
                    carry_d     = add_cout;
                    count_d     = count_q + CNT_W'(1);
`ifdef CSA_SEQ_ZFLAG_EN
                    zacc_d      = zacc_q && (add_sum == '0);
`endif
                    if (count_q == LAST_IDX) begin
                        state_d     = DRAIN;
                        res_last_d  = 1'b1;
                        carry_out_d = add_cout;
                        overflow_d  = (io.a_byte[BYTE_W-1] == add_b[BYTE_W-1]) &&
                                      (add_sum[BYTE_W-1] != io.a_byte[BYTE_W-1]);
`ifdef CSA_SEQ_ZFLAG_EN
                        zero_d      = zacc_q && (add_sum == '0);
`endif
                    end
                end
            end
            DRAIN: begin
                if (consume) begin
                    res_valid_d = 1'b0;
                    res_last_d  = 1'b0;
                    done_d      = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sub_q       <= 1'b0;
            carry_q     <= 1'b0;
            count_q     <= '0;
            res_byte_q  <= '0;
            res_valid_q <= 1'b0;
            res_last_q  <= 1'b0;
            done_q      <= 1'b0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
`ifdef CSA_SEQ_ZFLAG_EN
            zacc_q      <= 1'b0;
            zero_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sub_q       <= sub_d;
            carry_q     <= carry_d;
            count_q     <= count_d;
            res_byte_q  <= res_byte_d;
            res_valid_q <= res_valid_d;
            res_last_q  <= res_last_d;
            done_q      <= done_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
`ifdef CSA_SEQ_ZFLAG_EN
            zacc_q      <= zacc_d;
            zero_q      <= zero_d;
`endif
        end
    end

    assign io.in_ready  = in_ready_w;
    assign io.res_byte  = res_byte_q;
    assign io.res_valid = res_valid_q;
    assign io.res_last  = res_last_q;
    assign busy         = (state_q != IDLE);
    assign done         = done_q;
    assign carry_out    = carry_out_q;
    assign overflow     = overflow_q;
`ifdef CSA_SEQ_ZFLAG_EN
    assign zero         = zero_q;
`endif

endmodule

// File: tb/tb_csa_byte_sequencer.sv
// Randomized bench for csa_byte_sequencer against a whole-word arithmetic model.
module tb_csa_byte_sequencer;

    localparam int NB = 4;
    localparam int W  = NB * 8;

    typedef struct { logic [7:0] b; logic last; } exp_byte_t;
    typedef struct { logic c; logic o; logic z; } exp_fin_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic sub = 1'b0;
    logic [7:0] add_a, add_b, add_sum;
    logic add_cin, add_cout;
    logic busy, done, carry_out, overflow;
`ifdef CSA_SEQ_ZFLAG_EN
    logic zero;
`endif

    csa_byte_sequencer_if bus ();

    csa_byte_sequencer #(.NBYTES(NB)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .io(bus),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout),
        .busy(busy), .done(done), .carry_out(carry_out), .overflow(overflow)
`ifdef CSA_SEQ_ZFLAG_EN
        , .zero(zero)
`endif
    );

    // External 8-bit adder the sequencer drives.
    always_comb {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    exp_byte_t exp_q[$];
    exp_fin_t  fin_q[$];
    logic [7:0] got_q[$];
    logic done_pending = 1'b0;
    logic rand_ready = 1'b0;
    logic rand_gaps = 1'b0;
    logic bp_arm = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Result-side ready generator, with a one-shot 3-cycle stall after the first byte.
    initial begin
        bus.res_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (bp_arm && bus.res_valid) begin
                bp_arm = 1'b0;
                bus.res_ready = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    check("bp_in_ready", bus.in_ready, 0);
                    check("bp_res_held", bus.res_byte, 8'h01);
                    check("bp_res_valid", bus.res_valid, 1);
                    @(posedge clk); #1;
                end
                bus.res_ready = 1'b1;
            end else begin
                bus.res_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
        end
    end

    // Per-cycle comparison of the result stream and completion flags against the model.
    initial begin
        exp_byte_t e;
        exp_fin_t  f;
        forever begin
            @(negedge clk);
            if (!rst_n) continue;
            check("done", done, done_pending);
            if (done_pending) begin
                check("busy_in_done", busy, 0);
                if (fin_q.size() == 0) check("fin_missing", 1, 0);
                else begin
                    f = fin_q.pop_front();
                    check("carry_out", carry_out, f.c);
                    check("overflow", overflow, f.o);
`ifdef CSA_SEQ_ZFLAG_EN
                    check("zero", zero, f.z);
`endif
                end
            end
            done_pending = 1'b0;
            if (bus.res_valid && !bus.res_ready) check("stall_in_ready", bus.in_ready, 0);
            if (bus.res_valid && bus.res_ready) begin
                if (exp_q.size() == 0) check("unexpected_byte", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    check("res_byte", bus.res_byte, e.b);
                    check("res_last", bus.res_last, e.last);
                    got_q.push_back(bus.res_byte);
                    if (e.last) done_pending = 1'b1;
                end
            end
        end
    end

    task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic s,
                          input int abort_after);
        logic [63:0] mask, bb, res;
        logic [64:0] full;
        logic sa, sb, sr, ovf;
        int n, acc_cnt;
        logic acc;
        mask = (W == 64) ? '1 : ((64'd1 << W) - 64'd1);
        a &= mask;
        b &= mask;
        bb   = s ? (~b & mask) : b;
        full = {1'b0, a} + {1'b0, bb} + {64'd0, s};
        res  = full[63:0] & mask;
        sa = a[W-1]; sb = b[W-1]; sr = res[W-1];
        ovf = s ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
        for (int i = 0; i < NB; i++) exp_q.push_back('{b: res[8*i +: 8], last: (i == NB - 1)});
        fin_q.push_back('{c: full[W], o: ovf, z: (res == 64'd0)});
        got_q.delete();

        start = 1'b1; sub = s;
        @(posedge clk); #1;
        start = 1'b0; sub = $urandom_range(0, 1);
        acc_cnt = 0;
        for (int i = 0; i < NB; i++) begin
            if (rand_gaps && $urandom_range(0, 3) == 0) begin
                bus.in_valid = 1'b0;
                bus.a_byte = 8'($urandom);
                bus.b_byte = 8'($urandom);
                start = $urandom_range(0, 1);
                @(posedge clk); #1;
            end
            bus.in_valid = 1'b1;
            bus.a_byte = a[8*i +: 8];
            bus.b_byte = b[8*i +: 8];
            n = 0;
            forever begin
                @(negedge clk);
                acc = bus.in_ready;
                if (acc && i == 0) check("cin_first", add_cin, s);
                @(posedge clk); #1;
                if (acc) break;
                if (++n > 100) begin check("accept_timeout", 0, 1); break; end
            end
            acc_cnt++;
            if (i == NB - 1) start = 1'b0;
            if (abort_after == acc_cnt) begin
                rst_n = 1'b0;
                #1;
                check("rst_busy", busy, 0);
                check("rst_res_valid", bus.res_valid, 0);
                check("rst_in_ready", bus.in_ready, 0);
                check("rst_res_last", bus.res_last, 0);
                exp_q.delete(); fin_q.delete(); done_pending = 1'b0;
                bus.in_valid = 1'b0; start = 1'b0;
                @(posedge clk); #1;
                rst_n = 1'b1;
                @(posedge clk); #1;
                return;
            end
        end
        bus.in_valid = 1'b0;
        start = 1'b0;
        n = 0;
        forever begin
            @(negedge clk);
            if (done) break;
            if (++n > 200) begin check("done_timeout", 0, 1); break; end
        end
        @(posedge clk); #1;
    endtask

    task automatic check_lit(input string nm, input logic [31:0] word, input logic c, input logic o);
        check({nm, "_count"}, got_q.size(), NB);
        for (int i = 0; i < NB && i < got_q.size(); i++) check({nm, "_byte"}, got_q[i], word[8*i +: 8]);
        check({nm, "_carry"}, carry_out, c);
        check({nm, "_ovf"}, overflow, o);
    endtask

    initial begin
        logic [63:0] ra, rb;
        bus.in_valid = 1'b0;
        bus.a_byte = '0;
        bus.b_byte = '0;
        #1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_res_valid", bus.res_valid, 0);
        check("reset_res_byte", bus.res_byte, 0);
        check("reset_res_last", bus.res_last, 0);
        check("reset_in_ready", bus.in_ready, 0);
        check("reset_flags", {carry_out, overflow}, 0);
        check("reset_adder", {add_a, add_b, add_cin}, 0);
        #20;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(64'h0000_00FF, 64'h0000_0001, 1'b0, 0);
        check_lit("ff_plus_1", 32'h0000_0100, 1'b0, 1'b0);
        run_op(64'hFFFF_FFFF, 64'h0000_0001, 1'b0, 0);
        check_lit("wrap", 32'h0000_0000, 1'b1, 1'b0);
`ifdef CSA_SEQ_ZFLAG_EN
        check("wrap_zero", zero, 1);
`endif
        run_op(64'h0000_0005, 64'h0000_0007, 1'b1, 0);
        check_lit("sub_5_7", 32'hFFFF_FFFE, 1'b0, 1'b0);
        run_op(64'h7FFF_FFFF, 64'h0000_0001, 1'b0, 0);
        check_lit("pos_ovf", 32'h8000_0000, 1'b0, 1'b1);

        bp_arm = 1'b1;
        run_op(64'h00FF_80C0, 64'h0001_8041, 1'b0, 0);
        check_lit("backpressure", 32'h0101_0101, 1'b0, 1'b0);

        run_op(64'h1234_5678, 64'h0FFF_FFFF, 1'b0, 2);
        run_op(64'h0000_0002, 64'h0000_0003, 1'b0, 0);
        check_lit("after_reset", 32'h0000_0005, 1'b0, 1'b0);

        rand_ready = 1'b1;
        rand_gaps = 1'b1;
        for (int t = 0; t < 40; t++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            case ($urandom_range(0, 5))
                0: ra = '0;
                1: rb = '1;
                2: begin ra = 64'h8000_0000; rb = 64'h8000_0000; end
                3: rb = ra;
                default: ;
            endcase
            run_op(ra, rb, 1'($urandom_range(0, 1)), 0);
        end
        repeat (3) @(posedge clk);
        check("leftover_bytes", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/csa_byte_sequencer.md
Name: csa_byte_sequencer

Overview:
- Multi-byte add/subtract controller. It time-shares one external 8-bit carry-skip adder to compute NBYTES-wide sums, one byte per cycle, LSB first.
- Drives the adder's a/b/cin pins and registers each sum byte and its carry.
- Sits between the pin-level operand stream (ui_in/uio_in) and uo_out inside the tt_um top.

Parameters:
- NBYTES, 4, operand width in bytes (legal 1..8); byte counter is $clog2(NBYTES)+1 bits.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin operation; sampled only in IDLE
- sub  in  1  0=add, 1=subtract (A-B); latched with start
- in_valid  in  1  operand byte pair valid
- in_ready  out  1  operand byte pair accepted when in_valid&&in_ready
- a_byte  in  8  operand A byte
- b_byte  in  8  operand B byte
- add_a  out  8  to adder a
- add_b  out  8  to adder b
- add_cin  out  1  to adder carry-in
- add_sum  in  8  from adder sum
- add_cout  in  1  from adder carry-out
- res_byte  out  8  registered result byte
- res_valid  out  1  result byte valid
- res_ready  in  1  result byte consumed when res_valid&&res_ready
- res_last  out  1  qualifies res_byte as final (MSB) byte
- busy  out  1  high in RUN and DRAIN
- done  out  1  one-cycle pulse after final byte consumed
- carry_out  out  1  final adder carry (sub: 1 = no borrow); held until next start
- overflow  out  1  signed overflow of full-width result; held until next start

Behaviour:
- Reset (async, rst_n=0): state=IDLE. in_ready, res_valid, res_last, busy, done, carry_out, overflow all 0; res_byte=0; internal carry, byte count and sub latch all 0.
- States: IDLE, RUN, DRAIN.
- IDLE: start=1 -> RUN. Latch sub; carry_reg<=sub (cin=1 for two's-complement subtract); count<=0; clear carry_out/overflow.
- start in RUN/DRAIN is ignored.
- Adder drive (combinational): add_a=a_byte; add_b=sub_l ? ~b_byte : b_byte; add_cin=carry_reg. Outside RUN, add_a/add_b/add_cin are 0.
- in_ready = (state==RUN) && (!res_valid || res_ready).
- On accept (cycle t), at t+1:
  - res_byte<=add_sum, res_valid<=1, carry_reg<=add_cout, count<=count+1.
  - If count==NBYTES-1: res_last<=1, carry_out<=add_cout, overflow<=(a_byte[7]==add_b[7])&&(add_sum[7]!=a_byte[7]), state<=DRAIN.
- Latency: one cycle from accept to res_valid. Throughput is one byte per cycle when res_ready stays high.
- Result hold: res_valid and res_byte hold while res_ready=0. No accept occurs while res_valid&&!res_ready.
- res_valid clears on consume if no new accept occurs in the same cycle. Simultaneous consume and accept: res_valid stays 1 with the new byte.
- DRAIN: on consume of the last byte -> res_valid<=0, res_last<=0, done<=1 for one cycle, state<=IDLE.
- busy=0 in IDLE, including the done cycle.
- in_valid=0 in RUN: the sequencer waits indefinitely; carry_reg is preserved.
- NBYTES=1: the first accept goes directly to DRAIN.
- Count wrap is impossible; the counter resets on each start.
- Reset mid-operation: partial results are discarded and all outputs return to reset values immediately. The next start begins a fresh operation.

Optional Feature:
- Macro CSA_SEQ_ZFLAG_EN.
- Defined: adds output zero (1 bit), reset 0, cleared on start.
  - Internal all-zero accumulator is ANDed with (add_sum==0) on each accept.
  - zero is valid together with carry_out/overflow from the last-byte register update and held until the next start.
- Undefined: no zero port and no accumulator logic.

Decomposition:
- Package csa_seq_pkg: state enum (IDLE, RUN, DRAIN); BYTE_W=8.
- No sub-module. The adder core stays instantiated outside, at the tt_um top, and connects through the add_* ports, so it remains independently verifiable.

Test Plan:
- NBYTES=4, add 0x000000FF+0x00000001, res_ready=1 -> res bytes 00,01,00,00 on consecutive cycles; res_last on 4th; carry_out=0, overflow=0; done one cycle after the 4th byte.
- Add 0xFFFFFFFF+0x00000001 -> bytes 00,00,00,00; carry_out=1; overflow=0; (ZFLAG_EN) zero=1.
- sub=1, 0x00000005-0x00000007 -> bytes FE,FF,FF,FF; add_cin=1 on first accept; carry_out=0; overflow=0.
- Add 0x7FFFFFFF+0x00000001 -> bytes 00,00,00,80; overflow=1; carry_out=0.
- Backpressure: res_ready=0 for 3 cycles after first byte -> in_ready=0, res_byte held at 01. On res_ready=1, the stream resumes with correct carry into the next byte.
- Assert rst_n=0 after 2 accepted bytes -> immediately busy=0, res_valid=0, in_ready=0. A new start then add 0x00000002+0x00000003 -> 05,00,00,00, with no stale carry.
